// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// This block shares one picorv32-style valid/ready memory bus (the one that
// feeds the address decoder) between two masters:
//   - master 0 is the CPU
//   - master 1 is the DMA/copy engine
//
// Arbitration:
//   - Requests are granted round-robin.
//   - A grant is held for exactly one transaction.
//   - A one-cycle IDLE bubble follows every completion.
//   - Master 1 is not allowed into the MMIO window (addr[31:30] == 2'b11).
//     Such an access is answered locally with an error pulse and is never
//     forwarded to the slave.
//
// Optional feature:
//   Define MEM_BUS_ARBITER_TIMEOUT_EN to add a watchdog. The watchdog
//   completes a hung slave access after TIMEOUT_CYCLES busy cycles and
//   returns zero data.
//
// Parameters:
//   TIMEOUT_CYCLES      watchdog limit, legal range 2..65535
//
// Ports:
//   clk, reset_n        clock; synchronous active-low reset
//   mX_valid            master X request, held until mX_ready
//   mX_addr             master X address
//   mX_wdata            master X write data
//   mX_wstrb            master X byte strobes (0 = read)
//   mX_ready            one-cycle completion pulse to master X
//   mX_rdata            read data to master X, 0 unless mX_ready
//   s_valid             request to the decoder
//   s_addr              granted master's address, 0 when no grant
//   s_wdata             granted master's write data, 0 when no grant
//   s_wstrb             granted master's byte strobes, 0 when no grant
//   s_ready, s_rdata    decoder completion and read data
//   grant               one-hot owner (bit0 = m0, bit1 = m1)
//   m1_err              one-cycle pulse when an m1 MMIO access is blocked
//   timeout             one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        m1_err,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_M0 = 2'd1,
        BUSY_M1 = 2'd2,
        BLOCK   = 2'd3
    } state_t;

    state_t r_state;
    // Last-grant pointer: 1'b1 means m1 was granted last, so m0 wins a tie.
    logic   r_last;

    logic   w_pick_m1;
    logic   w_m1_mmio;
    logic   w_busy;
    logic   w_done;
    logic   w_wd_expire;

    if ((TIMEOUT_CYCLES < 32'sd2) || (TIMEOUT_CYCLES > 32'sd65535)) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 2..65535");
    end

    // On a tie, m1 wins only when m0 was the last master served.
    assign w_pick_m1 = m1_valid && (!m0_valid || !r_last);
    assign w_m1_mmio = (m1_addr[31:30] == 2'b11);
    assign w_busy    = (r_state == BUSY_M0) || (r_state == BUSY_M1);
    // A busy transaction ends on slave completion or on watchdog expiry.
    assign w_done    = s_ready || w_wd_expire;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wd_cnt;

    // When s_ready coincides with expiry, the slave response takes priority.
    assign w_wd_expire = w_busy && !s_ready && (r_wd_cnt == CNT_LAST);
`else
    assign w_wd_expire = 1'b0;
`endif

    // Arbiter FSM: state, last-grant pointer and watchdog counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
            r_wd_cnt <= {CNT_W{1'b0}};
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        r_last <= w_pick_m1;
                        if (w_pick_m1) begin
                            r_state <= w_m1_mmio ? BLOCK : BUSY_M1;
                        end else begin
                            r_state <= BUSY_M0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY_M0, BUSY_M1: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                BLOCK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
            // Holding the counter at zero in IDLE clears it on every BUSY entry.
            if (!w_busy) begin
                r_wd_cnt <= {CNT_W{1'b0}};
            end else if (!s_ready) begin
                r_wd_cnt <= r_wd_cnt + CNT_W'(1);
            end else begin
                r_wd_cnt <= r_wd_cnt;
            end
`endif
        end
    end

    // Bus and response steering, decoded from the current state.
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = 32'h0;
        s_wdata  = 32'h0;
        s_wstrb  = 4'h0;
        m0_ready = 1'b0;
        m0_rdata = 32'h0;
        m1_ready = 1'b0;
        m1_rdata = 32'h0;
        grant    = 2'b00;
        m1_err   = 1'b0;
        timeout  = 1'b0;
        case (r_state)
            BUSY_M0: begin
                grant   = 2'b01;
                s_valid = 1'b1;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
                if (s_ready) begin
                    m0_ready = 1'b1;
                    m0_rdata = s_rdata;
                end else if (w_wd_expire) begin
                    m0_ready = 1'b1;
                    timeout  = 1'b1;
                end else begin
                    m0_ready = 1'b0;
                end
            end
            BUSY_M1: begin
                grant   = 2'b10;
                s_valid = 1'b1;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
                if (s_ready) begin
                    m1_ready = 1'b1;
                    m1_rdata = s_rdata;
                end else if (w_wd_expire) begin
                    m1_ready = 1'b1;
                    timeout  = 1'b1;
                end else begin
                    m1_ready = 1'b0;
                end
            end
            BLOCK: begin
                // Blocked MMIO access: complete locally, never reach the slave.
                grant    = 2'b10;
                m1_ready = 1'b1;
                m1_err   = 1'b1;
            end
            IDLE: begin
                grant = 2'b00;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter.
//
// Structure:
//   - Each scenario task drives stimulus and checks the outputs inline.
//   - Randomized rounds are checked against a transaction-level model. The
//     model consists of:
//       - the serve order (round-robin pointer),
//       - completion cycles (grant latency + slave latency + IDLE bubble),
//       - the data each master must receive.
//   - The bench also plays the slave. It answers after a chosen number of
//     s_valid cycles.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
    logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
    logic [3:0]  m0_wstrb = 4'h0, m1_wstrb = 4'h0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  grant;
    logic        m1_err, timeout;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    // Model of the arbitration pointer: 1 means m1 was served last.
    logic model_last = 1'b1;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .m1_err(m1_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One arbitration round checked against the transaction-level model.
    task automatic run_round(input logic req0, input logic req1,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input int l0, input int l1);
        int          q[$];
        logic [31:0] addr [2];
        logic [31:0] wd [2];
        logic [3:0]  ws [2];
        int          lat [2];
        int          exp_done, lat_cnt, head, guard;
        logic        blk, in_win, exp_r, drop0, drop1;
        logic [1:0]  exp_g;
        logic [31:0] drv_rdata, exp_rd0, exp_rd1;
        addr[0] = a0;
        addr[1] = a1;
        wd[0]   = $urandom;
        wd[1]   = $urandom;
        ws[0]   = 4'($urandom_range(0, 15));
        ws[1]   = 4'($urandom_range(0, 15));
        lat[0]  = l0;
        lat[1]  = (a1[31:30] == 2'b11) ? 1 : l1;
        tick();
        m0_valid = req0; m0_addr = a0; m0_wdata = wd[0]; m0_wstrb = ws[0];
        m1_valid = req1; m1_addr = a1; m1_wdata = wd[1]; m1_wstrb = ws[1];
        s_ready  = 1'b0;
        if (req0 && req1) begin
            if (model_last) begin q.push_back(0); q.push_back(1); end
            else            begin q.push_back(1); q.push_back(0); end
        end else if (req0) begin
            q.push_back(0);
        end else begin
            q.push_back(1);
        end
        model_last = (q[q.size()-1] == 1);
        exp_done = cyc + lat[q[0]];
        lat_cnt  = 0;
        guard    = 0;
        while (q.size() > 0 && guard < 60) begin
            guard++;
            head = q[0];
            blk  = (head == 1) && (a1[31:30] == 2'b11);
            drv_rdata = $urandom;
            if (s_valid) begin
                lat_cnt++;
                s_ready = (lat_cnt == lat[head]);
            end else begin
                lat_cnt = 0;
                s_ready = 1'b0;
            end
            s_rdata = drv_rdata;
            @(negedge clk);
            in_win  = (cyc > exp_done - lat[head]) && (cyc <= exp_done);
            exp_r   = (cyc == exp_done);
            exp_g   = in_win ? ((head == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rd0 = (exp_r && head == 0) ? drv_rdata : 32'h0;
            exp_rd1 = (exp_r && head == 1 && !blk) ? drv_rdata : 32'h0;
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, grant, exp_g);
            end
            checks++;
            if (s_valid !== (in_win && !blk)) begin
                errors++;
                $display("FAIL rr_s_valid cyc=%0d got=%b exp=%b", cyc, s_valid, in_win && !blk);
            end
            checks++;
            if (in_win && !blk) begin
                if ({s_addr, s_wdata, s_wstrb} !== {addr[head], wd[head], ws[head]}) begin
                    errors++;
                    $display("FAIL rr_s_fields cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc,
                             s_addr, s_wdata, s_wstrb, addr[head], wd[head], ws[head]);
                end
            end else if ({s_addr, s_wdata, s_wstrb} !== 68'h0) begin
                errors++;
                $display("FAIL rr_s_idle_zero cyc=%0d got=%h/%h/%h exp=0", cyc, s_addr, s_wdata, s_wstrb);
            end
            checks++;
            if ({m0_ready, m1_ready, m1_err, timeout} !== {exp_r && head == 0, exp_r && head == 1, exp_r && blk, 1'b0}) begin
                errors++;
                $display("FAIL rr_ready cyc=%0d got=%b exp=%b", cyc, {m0_ready, m1_ready, m1_err, timeout},
                         {exp_r && head == 0, exp_r && head == 1, exp_r && blk, 1'b0});
            end
            checks++;
            if ({m0_rdata, m1_rdata} !== {exp_rd0, exp_rd1}) begin
                errors++;
                $display("FAIL rr_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, m0_rdata, m1_rdata, exp_rd0, exp_rd1);
            end
            drop0 = 1'b0;
            drop1 = 1'b0;
            if (exp_r) begin
                if (head == 0) drop0 = 1'b1; else drop1 = 1'b1;
                void'(q.pop_front());
                if (q.size() > 0) exp_done = cyc + 1 + lat[q[0]];
            end
            tick();
            if (drop0) m0_valid = 1'b0;
            if (drop1) m1_valid = 1'b0;
        end
        s_ready = 1'b0;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL rr_round_timeout pending=%0d exp=0", q.size());
            m0_valid = 1'b0;
            m1_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1;
        s_ready = 1'b1; s_rdata = 32'hA5A5_A5A5;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++;
        if ({s_valid, m0_ready, m1_ready, m1_err, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000", {s_valid, m0_ready, m1_ready, m1_err, timeout});
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", m0_rdata, m1_rdata); end
        checks++;
        if ({s_addr, s_wdata, s_wstrb} !== 68'h0) begin errors++; $display("FAIL reset_s_fields got=%h exp=0", s_addr); end
        tick();
        reset_n = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
        model_last = 1'b1;
    endtask

    task automatic test_single_read();
        tick();
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0; m0_wdata = 32'h0;
        @(negedge clk);
        checks++;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL single_n_s_valid got=%b exp=0", s_valid); end
        tick();
        @(negedge clk);
        checks++;
        if ({s_valid, grant, s_addr, m0_ready} !== {1'b1, 2'b01, 32'h0000_0010, 1'b0}) begin
            errors++;
            $display("FAIL single_grant got=%b/%b/%h/%b exp=1/01/00000010/0", s_valid, grant, s_addr, m0_ready);
        end
        tick();
        s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({m0_ready, m0_rdata, m1_ready, m1_rdata, grant} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 2'b01}) begin
            errors++;
            $display("FAIL single_done got=%b/%h/%b/%h exp=1/deadbeef/0/0", m0_ready, m0_rdata, m1_ready, m1_rdata);
        end
        tick();
        m0_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if ({grant, m0_ready, s_valid} !== 4'b0) begin
            errors++;
            $display("FAIL single_bubble got=%b/%b/%b exp=00/0/0", grant, m0_ready, s_valid);
        end
        model_last = 1'b0;
    endtask

    task automatic test_tie();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_last = 1'b1;
        run_round(1'b1, 1'b1, 32'h0000_0100, 32'h2000_0200, 1, 1);
        run_round(1'b1, 1'b1, 32'h0000_0300, 32'h2000_0400, 2, 3);
    endtask

    task automatic test_fence();
        run_round(1'b0, 1'b1, 32'h0, 32'hC200_0000, 1, 1);
        run_round(1'b0, 1'b1, 32'h0, 32'h4000_0000, 1, 2);
        run_round(1'b1, 1'b1, 32'hC000_0004, 32'hF000_0008, 2, 2);
    endtask

    task automatic test_watchdog();
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        tick();
        m0_valid = 1'b1; m0_addr = 32'h0000_2000; s_ready = 1'b0; s_rdata = 32'h1111_2222;
        for (int k = 1; k <= TO; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (k < TO) begin
                if ({m0_ready, timeout, s_valid} !== 3'b001) begin
                    errors++; $display("FAIL wd_wait k=%0d got=%b exp=001", k, {m0_ready, timeout, s_valid});
                end
            end else if ({m0_ready, timeout, s_valid, m0_rdata} !== {3'b111, 32'h0}) begin
                errors++;
                $display("FAIL wd_fire got=%b/%h exp=111/0", {m0_ready, timeout, s_valid}, m0_rdata);
            end
        end
        tick();
        m0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant, timeout} !== 3'b000) begin errors++; $display("FAIL wd_after got=%b/%b exp=00/0", grant, timeout); end
        tick();
        m0_valid = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO) begin s_ready = 1'b1; s_rdata = 32'h1234_5678; end
            @(negedge clk);
            checks++;
            if (k < TO) begin
                if ({m0_ready, timeout, s_valid} !== 3'b001) begin
                    errors++; $display("FAIL wd2_wait k=%0d got=%b exp=001", k, {m0_ready, timeout, s_valid});
                end
            end else if ({m0_ready, timeout, m0_rdata} !== {2'b10, 32'h1234_5678}) begin
                errors++;
                $display("FAIL wd_race got=%b/%b/%h exp=1/0/12345678", m0_ready, timeout, m0_rdata);
            end
        end
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        model_last = 1'b0;
`else
        tick();
        m0_valid = 1'b1; m0_addr = 32'h0000_2000; s_ready = 1'b0; s_rdata = 32'h1111_2222;
        for (int k = 1; k <= 20; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({m0_ready, timeout, s_valid} !== 3'b001) begin
                errors++; $display("FAIL nowd_wait k=%0d got=%b exp=001", k, {m0_ready, timeout, s_valid});
            end
        end
        tick();
        s_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({m0_ready, m0_rdata} !== {1'b1, 32'h1111_2222}) begin
            errors++; $display("FAIL nowd_done got=%b/%h exp=1/11112222", m0_ready, m0_rdata);
        end
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        model_last = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        tick();
        m1_valid = 1'b1; m1_addr = 32'h0000_0100; m1_wstrb = 4'h0; s_ready = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({grant, s_valid} !== 3'b101) begin errors++; $display("FAIL mid_busy got=%b/%b exp=10/1", grant, s_valid); end
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; m1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant, s_valid, m0_ready, m1_ready, m1_err, timeout, s_addr} !== 39'h0) begin
            errors++;
            $display("FAIL mid_reset_out got=%b/%b/%b/%h exp=0", grant, s_valid, m1_ready, s_addr);
        end
        tick();
        s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if ({m0_ready, m1_ready, m0_rdata, m1_rdata, grant} !== 68'h0) begin
            errors++;
            $display("FAIL stale_s_ready got=%b/%b/%h/%h exp=0", m0_ready, m1_ready, m0_rdata, m1_rdata);
        end
        tick();
        s_ready = 1'b0;
        model_last = 1'b1;
        run_round(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0080, 1, 1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int k;
            k = int'($urandom_range(1, 3));
            run_round(k[0], k[1], $urandom, $urandom, int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_fence();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
